// File: rtl/mem_crossbar_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_crossbar_pkg
//  Purpose  : Shared address map, target encoding and FSM state type for the
//             LSU-to-device crossbar and its LSU/difftest glue.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_crossbar_pkg;

    localparam int          DW            = 64;

    // MMIO register addresses (CLINT timer registers and UART TX data)
    localparam logic [63:0] MMIO_MTIME    = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] MMIO_MTIMECMP = 64'h0000_0000_0200_4000;
    localparam logic [63:0] UART_ADDR     = 64'h0000_0000_A000_03F8;

    // Data memory window
    localparam logic [63:0] DMEM_BASE     = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DMEM_SIZE     = 64'h0000_0000_0800_0000;

    // CLINT registers only accept full-width stores
    localparam logic [7:0]  WMASK_FULL    = 8'hFF;

    // Decoded slave target
    typedef enum logic [1:0] {
        TGT_DMEM  = 2'd0,
        TGT_CLINT = 2'd1,
        TGT_UART  = 2'd2,
        TGT_NONE  = 2'd3
    } tgt_e;

    // Crossbar transaction state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // MMIO targets are invisible to the reference model, so difftest skips them
    function automatic logic tgt_is_mmio(input tgt_e tgt);
        return (tgt == TGT_CLINT) || (tgt == TGT_UART);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_crossbar_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mxbar_addr_decode
//  Purpose  : Combinational byte-address to slave-target decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module mxbar_addr_decode
    import mem_crossbar_pkg::*;
#(
    parameter int              DW            = 64,
    parameter logic [DW-1:0]   DMEM_BASE     = 64'h8000_0000,
    parameter logic [DW-1:0]   DMEM_SIZE     = 64'h0800_0000,
    parameter logic [DW-1:0]   UART_ADDR     = 64'hA000_03F8,
    parameter logic [DW-1:0]   MTIME_ADDR    = 64'h0200_BFF8,
    parameter logic [DW-1:0]   MTIMECMP_ADDR = 64'h0200_4000
) (
    input  logic [DW-1:0] addr_i,
    output tgt_e          tgt_o
);

    // Offset into the DMEM window; comparing the offset against the size
    // avoids forming BASE+SIZE, which could wrap for windows at the top of
    // the address space.
    logic [DW-1:0] dmem_off;
    assign dmem_off = addr_i - DMEM_BASE;

    // Priority decode: DMEM window first, then the exact-match MMIO registers
    always_comb begin
        tgt_o = TGT_NONE;
        if ((addr_i >= DMEM_BASE) && (dmem_off < DMEM_SIZE)) begin
            tgt_o = TGT_DMEM;
        end else if ((addr_i == MTIME_ADDR) || (addr_i == MTIMECMP_ADDR)) begin
            tgt_o = TGT_CLINT;
        end else if (addr_i == UART_ADDR) begin
            tgt_o = TGT_UART;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_crossbar.sv
`default_nettype none
// ============================================================================
//  Module   : mem_crossbar
//  Purpose  : Single-outstanding LSU-to-device crossbar. Decodes each LSU
//             access to DMEM, CLINT, UART or unmapped, drives the selected
//             slave and returns one registered response with fault and
//             difftest-skip flags.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_crossbar
    import mem_crossbar_pkg::*;
#(
    parameter int            DW        = 64,
    parameter logic [DW-1:0] DMEM_BASE = 64'h8000_0000,
    parameter logic [DW-1:0] DMEM_SIZE = 64'h0800_0000,
    parameter logic [DW-1:0] UART_ADDR = 64'hA000_03F8
) (
    input  logic          mxbar_clk_i,
    input  logic          mxbar_rst_n_i,

    // LSU request
    input  logic          lsu_req_valid_i,
    output logic          lsu_req_ready_o,
    input  logic [DW-1:0] lsu_req_addr_i,
    input  logic          lsu_req_wen_i,
    input  logic [DW-1:0] lsu_req_wdata_i,
    input  logic [7:0]    lsu_req_wmask_i,

    // LSU response
    output logic          lsu_rsp_valid_o,
    input  logic          lsu_rsp_ready_i,
    output logic [DW-1:0] lsu_rsp_rdata_o,
    output logic          lsu_rsp_err_o,
    output logic          lsu_rsp_skip_o,

    // Data memory
    output logic          dmem_req_valid_o,
    input  logic          dmem_req_ready_i,
    output logic [DW-1:0] dmem_req_addr_o,
    output logic          dmem_req_wen_o,
    output logic [DW-1:0] dmem_req_wdata_o,
    output logic [7:0]    dmem_req_wmask_o,
    input  logic          dmem_rsp_valid_i,
    input  logic [DW-1:0] dmem_rsp_rdata_i,

    // CLINT (single-cycle, combinational read data)
    output logic          clint_ren_o,
    output logic          clint_wen_o,
    output logic [DW-1:0] clint_rwaddr_o,
    output logic [DW-1:0] clint_wdata_o,
    input  logic [DW-1:0] clint_rdata_i,

    // UART TX
    output logic          uart_valid_o,
    input  logic          uart_ready_i,
    output logic [7:0]    uart_wdata_o
);

    state_e        state_q, state_d;
    tgt_e          tgt_q,   tgt_d;
    logic [DW-1:0] addr_q,  addr_d;
    logic          wen_q,   wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    wmask_q, wmask_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q,   err_d;
    logic          skip_q,  skip_d;

    tgt_e          req_tgt;

    mxbar_addr_decode #(
        .DW            (DW),
        .DMEM_BASE     (DMEM_BASE),
        .DMEM_SIZE     (DMEM_SIZE),
        .UART_ADDR     (UART_ADDR),
        .MTIME_ADDR    (DW'(MMIO_MTIME)),
        .MTIMECMP_ADDR (DW'(MMIO_MTIMECMP))
    ) u_addr_decode (
        .addr_i (lsu_req_addr_i),
        .tgt_o  (req_tgt)
    );

    // State and transaction registers; reset drops any in-flight access
    always_ff @(posedge mxbar_clk_i or negedge mxbar_rst_n_i) begin
        if (!mxbar_rst_n_i) begin
            state_q <= ST_IDLE;
            tgt_q   <= TGT_NONE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state logic and slave/LSU handshake strobes
    always_comb begin
        state_d          = state_q;
        tgt_d            = tgt_q;
        addr_d           = addr_q;
        wen_d            = wen_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        rdata_d          = rdata_q;
        err_d            = err_q;
        skip_d           = skip_q;
        lsu_req_ready_o  = 1'b0;
        lsu_rsp_valid_o  = 1'b0;
        dmem_req_valid_o = 1'b0;
        clint_ren_o      = 1'b0;
        clint_wen_o      = 1'b0;
        uart_valid_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lsu_req_ready_o = 1'b1;
                if (lsu_req_valid_i) begin
                    addr_d  = lsu_req_addr_i;
                    wen_d   = lsu_req_wen_i;
                    wdata_d = lsu_req_wdata_i;
                    wmask_d = lsu_req_wmask_i;
                    tgt_d   = req_tgt;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    skip_d  = tgt_is_mmio(req_tgt);
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                case (tgt_q)
                    TGT_CLINT: begin
                        // Partial stores to the 64-bit timer registers fault
                        if (wen_q && (wmask_q != WMASK_FULL)) begin
                            err_d = 1'b1;
                        end else begin
                            clint_ren_o = !wen_q;
                            clint_wen_o = wen_q;
                            if (!wen_q) begin
                                rdata_d = clint_rdata_i;
                            end
                        end
                        state_d = ST_RESP;
                    end
                    TGT_UART: begin
                        // TX data register is write-only
                        if (!wen_q) begin
                            err_d   = 1'b1;
                            state_d = ST_RESP;
                        end else begin
                            uart_valid_o = 1'b1;
                            if (uart_ready_i) begin
                                state_d = ST_RESP;
                            end
                        end
                    end
                    TGT_DMEM: begin
                        dmem_req_valid_o = 1'b1;
                        if (dmem_req_ready_i) begin
                            state_d = ST_WAIT;
                        end
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                endcase
            end

            ST_WAIT: begin
                if (dmem_rsp_valid_i) begin
                    if (!wen_q) begin
                        rdata_d = dmem_rsp_rdata_i;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                lsu_rsp_valid_o = 1'b1;
                if (lsu_rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Slave payloads come straight from the latched request so they stay
    // stable for the whole handshake
    assign dmem_req_addr_o  = addr_q;
    assign dmem_req_wen_o   = wen_q;
    assign dmem_req_wdata_o = wdata_q;
    assign dmem_req_wmask_o = wmask_q;
    assign clint_rwaddr_o   = addr_q;
    assign clint_wdata_o    = wdata_q;
    assign uart_wdata_o     = wdata_q[7:0];

    assign lsu_rsp_rdata_o  = rdata_q;
    assign lsu_rsp_err_o    = err_q;
    assign lsu_rsp_skip_o   = skip_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_crossbar.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_crossbar
//  Purpose  : Scoreboard bench for mem_crossbar with randomized slaves.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_crossbar;
    import mem_crossbar_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        lsu_req_valid_i = 1'b0, lsu_req_ready_o;
    logic [63:0] lsu_req_addr_i = '0, lsu_req_wdata_i = '0;
    logic        lsu_req_wen_i = 1'b0;
    logic [7:0]  lsu_req_wmask_i = '0;
    logic        lsu_rsp_valid_o, lsu_rsp_ready_i = 1'b0;
    logic [63:0] lsu_rsp_rdata_o;
    logic        lsu_rsp_err_o, lsu_rsp_skip_o;
    logic        dmem_req_valid_o, dmem_req_ready_i = 1'b0;
    logic [63:0] dmem_req_addr_o, dmem_req_wdata_o;
    logic        dmem_req_wen_o;
    logic [7:0]  dmem_req_wmask_o;
    logic        dmem_rsp_valid_i = 1'b0;
    logic [63:0] dmem_rsp_rdata_i = '0;
    logic        clint_ren_o, clint_wen_o;
    logic [63:0] clint_rwaddr_o, clint_wdata_o, clint_rdata_i = '0;
    logic        uart_valid_o, uart_ready_i = 1'b0;
    logic [7:0]  uart_wdata_o;

    mem_crossbar dut (
        .mxbar_clk_i      (clk),
        .mxbar_rst_n_i    (rst_n),
        .lsu_req_valid_i  (lsu_req_valid_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_req_addr_i   (lsu_req_addr_i),
        .lsu_req_wen_i    (lsu_req_wen_i),
        .lsu_req_wdata_i  (lsu_req_wdata_i),
        .lsu_req_wmask_i  (lsu_req_wmask_i),
        .lsu_rsp_valid_o  (lsu_rsp_valid_o),
        .lsu_rsp_ready_i  (lsu_rsp_ready_i),
        .lsu_rsp_rdata_o  (lsu_rsp_rdata_o),
        .lsu_rsp_err_o    (lsu_rsp_err_o),
        .lsu_rsp_skip_o   (lsu_rsp_skip_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_req_addr_o  (dmem_req_addr_o),
        .dmem_req_wen_o   (dmem_req_wen_o),
        .dmem_req_wdata_o (dmem_req_wdata_o),
        .dmem_req_wmask_o (dmem_req_wmask_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rsp_rdata_i (dmem_rsp_rdata_i),
        .clint_ren_o      (clint_ren_o),
        .clint_wen_o      (clint_wen_o),
        .clint_rwaddr_o   (clint_rwaddr_o),
        .clint_wdata_o    (clint_wdata_o),
        .clint_rdata_i    (clint_rdata_i),
        .uart_valid_o     (uart_valid_o),
        .uart_ready_i     (uart_ready_i),
        .uart_wdata_o     (uart_wdata_o)
    );

    // Expected outcome of one LSU access
    typedef struct {
        logic [63:0] addr, wdata, rdata;
        logic [7:0]  wmask;
        logic        wen, err, skip;
        int          n_clint, n_uart, n_dmem, uvc, acc_cyc;
        bit          fast;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0, cyc = 0;
    int   dmem_lat_force = -1, uart_force = -1, rsp_hold = 0;
    bit   dmem_hs_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Contents the DMEM slave returns for a load
    function automatic logic [63:0] dmem_data(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
    endfunction

    // Reference model: outcome of an access from the address map rules
    function automatic exp_t model(input logic [63:0] a, input logic w, input logic [63:0] d,
                                   input logic [7:0] m, input logic [63:0] cv);
        exp_t e;
        e.addr = a; e.wen = w; e.wdata = d; e.wmask = m;
        e.rdata = '0; e.err = 1'b0; e.skip = 1'b0;
        e.n_clint = 0; e.n_uart = 0; e.n_dmem = 0; e.uvc = -1; e.acc_cyc = 0; e.fast = 1'b1;
        if (a >= DMEM_BASE && a < DMEM_BASE + DMEM_SIZE) begin
            e.n_dmem = 1; e.fast = 1'b0;
            if (!w) e.rdata = dmem_data(a);
        end else if (a == MMIO_MTIME || a == MMIO_MTIMECMP) begin
            e.skip = 1'b1;
            if (w && m != 8'hFF) e.err = 1'b1;
            else begin
                e.n_clint = 1;
                if (!w) e.rdata = cv;
            end
        end else if (a == UART_ADDR) begin
            e.skip = 1'b1;
            if (!w) e.err = 1'b1;
            else begin e.n_uart = 1; e.fast = 1'b0; end
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Present one request, push its expectation on acceptance
    task automatic issue(input logic [63:0] a, input logic w, input logic [63:0] d,
                         input logic [7:0] m, input int uvc_exp);
        logic [63:0] cv;
        exp_t e;
        cv = {$urandom, $urandom};
        e = model(a, w, d, m, cv);
        e.uvc = uvc_exp;
        lsu_req_addr_i = a; lsu_req_wen_i = w; lsu_req_wdata_i = d; lsu_req_wmask_i = m;
        lsu_req_valid_i = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (lsu_req_ready_o) begin
                e.acc_cyc = cyc;
                sb.push_back(e);
                @(posedge clk); #1;
                lsu_req_valid_i = 1'b0;
                clint_rdata_i = cv;
                return;
            end
        end
        fail("req_accept_timeout");
        lsu_req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) fail("drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rsp_valid"}, lsu_rsp_valid_o, 0);
        chk({tag, "_rsp_rdata"}, lsu_rsp_rdata_o, 0);
        chk({tag, "_rsp_err_skip"}, {lsu_rsp_err_o, lsu_rsp_skip_o}, 0);
        chk({tag, "_strobes"}, {clint_ren_o, clint_wen_o, uart_valid_o, dmem_req_valid_o}, 0);
        chk({tag, "_dmem_addr"}, dmem_req_addr_o, 0);
        chk({tag, "_uart_wdata"}, uart_wdata_o, 0);
    endtask

    // DMEM slave: random request acceptance, random response latency
    initial begin : dmem_slave
        bit hs, pend;
        logic [63:0] hs_addr, p_addr;
        int lat;
        pend = 1'b0; lat = 0; p_addr = '0;
        forever begin
            @(negedge clk);
            hs = rst_n && dmem_req_valid_o && dmem_req_ready_i;
            hs_addr = dmem_req_addr_o;
            @(posedge clk); #1;
            dmem_rsp_valid_i = 1'b0;
            dmem_rsp_rdata_i = {$urandom, $urandom};
            if (hs) begin
                pend = 1'b1; p_addr = hs_addr;
                lat = (dmem_lat_force >= 0) ? dmem_lat_force : int'($urandom_range(0, 3));
            end else if (pend) begin
                if (lat == 0) begin
                    dmem_rsp_valid_i = 1'b1;
                    dmem_rsp_rdata_i = dmem_data(p_addr);
                    pend = 1'b0;
                end else lat--;
            end
            dmem_req_ready_i = ($urandom % 3) != 0;
        end
    end

    // UART slave: random ready, or ready after a forced number of stalls
    initial begin : uart_slave
        int vcnt;
        vcnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n && uart_valid_o) begin
                if (uart_ready_i) vcnt = 0;
                else vcnt++;
            end
            @(posedge clk); #1;
            uart_ready_i = (uart_force >= 0) ? (vcnt >= uart_force) : ($urandom % 2 == 1);
        end
    end

    // LSU response acceptance: random, or held off for rsp_hold valid cycles
    initial begin : rsp_sink
        forever begin
            @(posedge clk); #1;
            if (rsp_hold > 0) begin
                lsu_rsp_ready_i = 1'b0;
                if (lsu_rsp_valid_o) rsp_hold--;
            end else begin
                lsu_rsp_ready_i = ($urandom % 4) != 0;
            end
        end
    end

    // Monitor: slave strobes and LSU responses against the scoreboard
    int          n_clint = 0, n_uart = 0, n_uvc = 0, n_dmem = 0;
    bit          seen_valid = 1'b0, prev_hold = 1'b0;
    logic [63:0] h_rdata;
    logic        h_err, h_skip;

    always @(negedge clk) begin
        if (!rst_n) begin
            n_clint = 0; n_uart = 0; n_uvc = 0; n_dmem = 0;
            seen_valid = 1'b0; prev_hold = 1'b0;
        end else begin
            if (clint_ren_o || clint_wen_o) begin
                n_clint++;
                if (sb.size() == 0) fail("clint_strobe_without_request");
                else begin
                    chk("clint_wen", clint_wen_o, sb[0].wen);
                    chk("clint_ren", clint_ren_o, !sb[0].wen);
                    chk("clint_addr", clint_rwaddr_o, sb[0].addr);
                    if (sb[0].wen) chk("clint_wdata", clint_wdata_o, sb[0].wdata);
                end
            end
            if (uart_valid_o) begin
                n_uvc++;
                if (uart_ready_i) n_uart++;
                if (sb.size() == 0) fail("uart_strobe_without_request");
                else chk("uart_wdata", uart_wdata_o, sb[0].wdata[7:0]);
            end
            if (dmem_req_valid_o && dmem_req_ready_i) begin
                n_dmem++;
                dmem_hs_seen = 1'b1;
                if (sb.size() == 0) fail("dmem_req_without_request");
                else begin
                    chk("dmem_addr", dmem_req_addr_o, sb[0].addr);
                    chk("dmem_wen", dmem_req_wen_o, sb[0].wen);
                    chk("dmem_wdata", dmem_req_wdata_o, sb[0].wdata);
                    chk("dmem_wmask", dmem_req_wmask_o, sb[0].wmask);
                end
            end
            if (lsu_rsp_valid_o) begin
                chk("req_ready_during_rsp", lsu_req_ready_o, 0);
                chk("strobe_during_rsp", {clint_ren_o, clint_wen_o, uart_valid_o, dmem_req_valid_o}, 0);
                if (prev_hold) begin
                    chk("hold_rdata", lsu_rsp_rdata_o, h_rdata);
                    chk("hold_err_skip", {lsu_rsp_err_o, lsu_rsp_skip_o}, {h_err, h_skip});
                end
                if (sb.size() == 0) fail("rsp_without_request");
                else begin
                    if (!seen_valid && sb[0].fast) chk("min_latency", cyc - sb[0].acc_cyc, 2);
                    seen_valid = 1'b1;
                    if (lsu_rsp_ready_i) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("rsp_rdata", lsu_rsp_rdata_o, e.rdata);
                        chk("rsp_err", lsu_rsp_err_o, e.err);
                        chk("rsp_skip", lsu_rsp_skip_o, e.skip);
                        chk("clint_cycles", n_clint, e.n_clint);
                        chk("uart_handshakes", n_uart, e.n_uart);
                        chk("dmem_handshakes", n_dmem, e.n_dmem);
                        if (e.uvc >= 0) chk("uart_valid_cycles", n_uvc, e.uvc);
                        n_clint = 0; n_uart = 0; n_uvc = 0; n_dmem = 0;
                        seen_valid = 1'b0;
                    end
                end
                prev_hold = !lsu_rsp_ready_i;
                h_rdata = lsu_rsp_rdata_o; h_err = lsu_rsp_err_o; h_skip = lsu_rsp_skip_o;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] a, d;
        logic [7:0]  m;
        logic        w;
        int          sel;

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // DMEM load inside the window
        issue(64'h8000_0010, 1'b0, 64'h0, 8'hFF, -1);
        // CLINT store, full and partial mask; CLINT load
        issue(MMIO_MTIMECMP, 1'b1, 64'h5, 8'hFF, -1);
        issue(MMIO_MTIMECMP, 1'b1, 64'h5, 8'h0F, -1);
        issue(MMIO_MTIME, 1'b0, 64'h0, 8'hFF, -1);
        drain();

        // UART store stalled 3 cycles, then a UART load
        uart_force = 3;
        issue(UART_ADDR, 1'b1, 64'h41, 8'h01, 4);
        issue(UART_ADDR, 1'b0, 64'h0, 8'hFF, -1);
        drain();
        uart_force = -1;

        // Unmapped and window-edge addresses
        issue(64'h0000_1000, 1'b0, 64'h0, 8'hFF, -1);
        issue(DMEM_BASE + DMEM_SIZE, 1'b0, 64'h0, 8'hFF, -1);
        issue(DMEM_BASE + DMEM_SIZE - 64'd8, 1'b0, 64'h0, 8'hFF, -1);
        issue(DMEM_BASE - 64'd8, 1'b1, 64'h1234, 8'hFF, -1);
        drain();

        // Back-to-back requests with the response held off
        rsp_hold = 5;
        issue(MMIO_MTIME, 1'b0, 64'h0, 8'hFF, -1);
        issue(64'h8000_0100, 1'b1, 64'hCAFE, 8'h3C, -1);
        drain();

        // Reset while waiting for a DMEM response
        dmem_lat_force = 4;
        dmem_hs_seen = 1'b0;
        issue(64'h8000_0200, 1'b0, 64'h0, 8'hFF, -1);
        for (int k = 0; k < 100 && !dmem_hs_seen; k++) @(negedge clk);
        if (!dmem_hs_seen) fail("dmem_handshake_timeout");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk_idle_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_reset_rsp_valid", lsu_rsp_valid_o, 0);
        end
        dmem_lat_force = -1;
        @(posedge clk); #1;
        issue(MMIO_MTIME, 1'b0, 64'h0, 8'hFF, -1);
        drain();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom % 6);
            case (sel)
                0, 5: a = DMEM_BASE + (64'($urandom % 32'h0100_0000) << 3);
                1: begin
                    case ($urandom % 4)
                        0: a = DMEM_BASE;
                        1: a = DMEM_BASE + DMEM_SIZE - 64'd1;
                        2: a = DMEM_BASE + DMEM_SIZE;
                        default: a = DMEM_BASE - 64'd1;
                    endcase
                end
                2: a = ($urandom % 2) ? MMIO_MTIME : MMIO_MTIMECMP;
                3: a = UART_ADDR;
                default: a = {$urandom, $urandom};
            endcase
            w = $urandom % 2 == 1;
            d = {$urandom, $urandom};
            m = ($urandom % 2) ? 8'hFF : 8'($urandom);
            issue(a, w, d, m, -1);
            repeat ($urandom % 3) begin @(posedge clk); #1; end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
